// File: rtl/reg_command_sequencer.sv
// -----------------------------------------------------------------------------
// reg_command_sequencer
//
// Turns single commands into the enable / function-select / data sequence that
// drives a 16-bit register with DEC, INC, CLR, load-low and load-high
// functions.
//
//   DEC/INC : CmdCount+1 back-to-back E pulses with FunSel 000/001.
//   CLR     : one E pulse with FunSel 011.
//   LOADW   : waits for a low then a high data byte; each accepted byte yields
//             one E pulse (FunSel 100 with the low byte, FunSel 110 with the
//             high byte). A byte gap of BYTE_TIMEOUT cycles aborts the
//             command with an Error pulse.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   synchronous, active-high reset
//   CmdValid   in   command offered
//   CmdReady   out  command accepted this cycle if CmdValid (IDLE decode)
//   CmdOp      in   [1:0] 00 DEC, 01 INC, 10 CLR, 11 LOADW
//   CmdCount   in   [3:0] repeat count for DEC/INC (applied CmdCount+1 times)
//   ByteValid  in   data byte offered (LOADW only)
//   ByteReady  out  byte accepted this cycle if ByteValid
//   ByteIn     in   [7:0] data byte, low byte first
//   E          out  registered register enable
//   FunSel     out  [2:0] registered register function select
//   I          out  [15:0] registered register data
//   Done       out  registered pulse on the last E cycle of a command
//   Error      out  registered pulse on a LOADW byte timeout
// -----------------------------------------------------------------------------
module reg_command_sequencer #(
  parameter int BYTE_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [3:0]  CmdCount,
  input  logic        ByteValid,
  output logic        ByteReady,
  input  logic [7:0]  ByteIn,
  output logic        E,
  output logic [2:0]  FunSel,
  output logic [15:0] I,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP    = 3'd1,
    CLR     = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  localparam logic [1:0] OP_DEC   = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_LOADW = 2'b11;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_LOAD_LO = 3'b100;
  localparam logic [2:0] FS_LOAD_HI = 3'b110;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(BYTE_TIMEOUT);

  state_t      state, state_d;
  logic [3:0]  step_cnt, step_cnt_d;     // E pulses still to issue after this one
  logic        step_inc_q, step_inc_d;   // 1 = INC, 0 = DEC for the running STEP
  logic [15:0] idle_cnt, idle_cnt_d;     // consecutive cycles without a byte accept
  logic [16:0] idle_cnt_inc;

  logic        e_d;
  logic [2:0]  funsel_d;
  logic [15:0] i_d;
  logic        done_d;
  logic        error_d;

  logic        cmd_accept;
  logic        byte_accept;
  logic        byte_timeout;

  // Handshake decodes. In WAIT_HI the register E pulse of a byte load is
  // issued while the state still reads WAIT_HI, so ByteReady is masked by E:
  // that keeps E and ByteReady mutually exclusive and stops a byte from being
  // taken while the previous one is being written.
  assign CmdReady    = (state == IDLE);
  assign ByteReady   = (state == WAIT_LO) || ((state == WAIT_HI) && !E);
  assign cmd_accept  = CmdValid && CmdReady;
  assign byte_accept = ByteValid && ByteReady;

  // The timeout fires on the edge at which the idle counter would reach the
  // limit, so Error is visible in the cycle where the count equals the limit.
  assign idle_cnt_inc = {1'b0, idle_cnt} + 17'd1;
  assign byte_timeout = !byte_accept && (idle_cnt_inc == TIMEOUT_LIMIT);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop here uses a non-blocking assignment so all registers
  // update together from the values computed in the combinational processes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      step_cnt   <= '0;
      step_inc_q <= 1'b0;
      idle_cnt   <= '0;
      E          <= 1'b0;
      FunSel     <= '0;
      I          <= '0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      state      <= state_d;
      step_cnt   <= step_cnt_d;
      step_inc_q <= step_inc_d;
      idle_cnt   <= idle_cnt_d;
      E          <= e_d;
      FunSel     <= funsel_d;
      I          <= i_d;
      Done       <= done_d;
      Error      <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    step_cnt_d = step_cnt;
    step_inc_d = step_inc_q;
    idle_cnt_d = idle_cnt;

    case (state)
      IDLE: begin
        if (cmd_accept) begin
          step_cnt_d = CmdCount;
          step_inc_d = (CmdOp == OP_INC);
          idle_cnt_d = '0;
          case (CmdOp)
            OP_DEC, OP_INC: state_d = STEP;
            OP_CLR:         state_d = CLR;
            default:        state_d = WAIT_LO;
          endcase
        end
      end

      STEP: begin
        // The current cycle carries an E pulse; leave once the last has run.
        if (step_cnt == 4'd0) begin
          state_d = IDLE;
        end else begin
          step_cnt_d = step_cnt - 4'd1;
        end
      end

      CLR: state_d = IDLE;

      WAIT_LO: begin
        if (byte_accept) begin
          idle_cnt_d = '0;
          state_d    = WAIT_HI;
        end else if (byte_timeout) begin
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_inc[15:0];
        end
      end

      WAIT_HI: begin
        // Done high here marks the final high-byte write cycle.
        if (Done) begin
          state_d = IDLE;
        end else if (byte_accept) begin
          idle_cnt_d = '0;
        end else if (byte_timeout) begin
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_inc[15:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: values the output registers take on the next edge
  // ---------------------------------------------------------------------------
  always_comb begin
    e_d      = 1'b0;
    funsel_d = FS_DEC;
    i_d      = '0;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_accept) begin
          case (CmdOp)
            OP_DEC: begin
              e_d      = 1'b1;
              funsel_d = FS_DEC;
              done_d   = (CmdCount == 4'd0);
            end
            OP_INC: begin
              e_d      = 1'b1;
              funsel_d = FS_INC;
              done_d   = (CmdCount == 4'd0);
            end
            OP_CLR: begin
              e_d      = 1'b1;
              funsel_d = FS_CLR;
              done_d   = 1'b1;
            end
            default: ;  // LOADW issues nothing until a byte arrives
          endcase
        end
      end

      STEP: begin
        if (step_cnt != 4'd0) begin
          e_d      = 1'b1;
          funsel_d = step_inc_q ? FS_INC : FS_DEC;
          done_d   = (step_cnt == 4'd1);
        end
      end

      WAIT_LO: begin
        if (byte_accept) begin
          e_d      = 1'b1;
          funsel_d = FS_LOAD_LO;
          i_d      = {8'h00, ByteIn};
        end else if (byte_timeout) begin
          error_d = 1'b1;
        end
      end

      WAIT_HI: begin
        if (Done) begin
          // final write cycle of the command, nothing further to issue
        end else if (byte_accept) begin
          e_d      = 1'b1;
          funsel_d = FS_LOAD_HI;
          i_d      = {8'h00, ByteIn};
          done_d   = 1'b1;
        end else if (byte_timeout) begin
          error_d = 1'b1;
        end
      end

      default: ;
    endcase
  end

endmodule
